capture_downsampler: RTL and testbench
======================================

# capture_downsampler

Consumes the RGB565 pixel stream produced by the camera capture stage and converts one armed frame into a 28x28 grayscale image for the digit classifier. It crops a centred 448x448 window, converts each pixel to 8-bit luma, and box-averages 16x16 blocks. It writes each result into the downstream 784-entry image buffer. It sits between capture (driven by the pclk-synchronised pixel stream, already moved to the system clock) and the recognition core.

## Interface
- SRC_W, 640, source pixels per line
- SRC_H, 480, source lines per frame
- OUT_DIM, 28, output image is OUT_DIM x OUT_DIM
- BLOCK, 16, block edge in source pixels (power of two)
- X0, (SRC_W-OUT_DIM*BLOCK)/2 = 96, first cropped column
- Y0, (SRC_H-OUT_DIM*BLOCK)/2 = 16, first cropped line

- clk_100MHz  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-high
- arm  in  1  single-cycle request to process the next frame (debounced btn_photo)
- pix_valid  in  1  pixel qualifier
- pix_data  in  16  RGB565 {R5,G6,B5}
- pix_sof  in  1  with pix_valid: this pixel is (0,0) of a frame
- pix_eol  in  1  with pix_valid: last pixel of a line
- wr_en  out  1  image buffer write strobe
- wr_addr  out  10  row*OUT_DIM+col, 0..783
- wr_data  out  8  block average luma
- busy  out  1  high in WAIT_SOF and ACTIVE
- frame_done  out  1  one-cycle pulse after the final write

## Operation
- States: IDLE, WAIT_SOF, ACTIVE.
  - IDLE->WAIT_SOF on arm.
  - WAIT_SOF->ACTIVE on pix_valid&pix_sof; that pixel is processed as (0,0).
  - ACTIVE->IDLE after the write of address 783.
- arm is ignored outside IDLE. pix_valid is ignored in IDLE and in WAIT_SOF without sof.
- Counters x (0..SRC_W-1) and y (0..SRC_H-1) are set to (0,0) by sof.
  - x increments per accepted pixel. eol sets x=0 and increments y.
  - Pixels with x>=SRC_W are dropped. eol still applies to them.
  - Lines with y>=SRC_H are dropped.
- Crop: a pixel is in-window iff X0<=x<X0+OUT_DIM*BLOCK and Y0<=y<Y0+OUT_DIM*BLOCK. Then col=(x-X0)/BLOCK, row=(y-Y0)/BLOCK, bx=(x-X0)%BLOCK, by=(y-Y0)%BLOCK.
- Luma: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}; gray=(R8+2*G8+B8)>>2, 10-bit sum, truncating shift.
- Accumulation: OUT_DIM accumulators, each 16 bit (log2(BLOCK*BLOCK)+8). Each in-window pixel adds gray to acc[col].
  - On the pixel with bx=BLOCK-1 and by=BLOCK-1: emit wr_data=(acc[col]+gray)>>8 and wr_addr=row*OUT_DIM+col, and clear acc[col] to 0 in the same update.
  - No overflow is possible by construction.
- sof while ACTIVE: abort the frame, clear all accumulators, restart at (0,0). Writes already issued stand.
- Frame ends short (an early sof, or the stream stops): no frame_done. The FSM waits in ACTIVE; a later sof restarts.

## Timing
- Pipeline: S1 registers gray, col, row and emit-flag; S2 updates acc and drives the write.
- wr_en is high exactly 2 cycles after the clock edge that accepted the emitting pixel, and is one cycle wide.
- frame_done is asserted the cycle after the wr_en for address 783. busy falls in that same cycle.
- Back-to-back pix_valid every cycle is supported. Throughput is 1 pixel/clock with no stall and no ready signal.
- Reset values: state IDLE, x=y=0, all acc=0, pipeline valids 0, wr_en=0, wr_addr=0, wr_data=0, busy=0, frame_done=0.
- Reset mid-frame discards everything. Reset dominates arm and sof in the same cycle.

## Structure
- Package cam_pkg holds the constants and typedefs:
  - OUT_DIM, BLOCK, the SRC_W/SRC_H defaults, IMG_WORDS=784
  - the rgb565_t packed struct
  - the cd_state_t enum
- Sub-module rgb565_to_gray: purely combinational luma function, instantiated in S1.
- Accumulators are a register array (28x16). There is no RAM inference.

## Test plan
- Uniform frame 0xFFFF after arm -> 784 writes, addresses 0..783 in order, all wr_data=0xFF; frame_done once, 1 cycle after the last write.
- Uniform 0x0000 frame; a second frame streamed without re-arm -> 784 writes of 0x00, then no writes during the second frame, busy=0.
- Only block (row 3, col 5) set to 0xF800 (pure red), rest black -> addr 89 gets (248+0+0... R8=0xFF → gray=(255)>>2=63), all others 0.
- Pixel (x=96,y=16)=0xFFFF and (x=95,y=16)=0xFFFF, rest black -> addr 0 gets (255>>8)=0, since the sum 255 is under the 256 threshold for a nonzero average; the out-of-crop pixel contributes nothing. Repeat with a full 0xFFFF 16x16 block at the window origin -> addr 0 = 0xFF.
- sof injected at y=200 mid-frame, then a full 0xFFFF frame -> the resumed frame emits exactly 784 writes, all 0xFF, with no residue from before the abort.
- Reset asserted for 1 cycle while ACTIVE -> all outputs 0 the next cycle, state IDLE; arm plus a new frame completes normally.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared constants and types for the camera capture / downsampling path.
// Holds the default frame geometry, the output image size and the FSM state type.
package cam_pkg;

  localparam int OUT_DIM       = 28;
  localparam int BLOCK         = 16;
  localparam int SRC_W_DEFAULT = 640;
  localparam int SRC_H_DEFAULT = 480;
  localparam int IMG_WORDS     = OUT_DIM * OUT_DIM;
  localparam int ADDR_W        = 10;
  localparam int GRAY_W        = 8;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    ACTIVE   = 2'd2
  } cd_state_t;

endpackage

// File: rtl/rgb565_to_gray.sv
// Combinational RGB565 -> 8-bit luma: channels widened by bit replication,
// then gray = (R + 2G + B) / 4 with truncation.
module rgb565_to_gray
  import cam_pkg::*;
(
  input  logic [15:0] pix,
  output logic [7:0]  gray
);

  rgb565_t    p;
  logic [7:0] r8;
  logic [7:0] g8;
  logic [7:0] b8;
  logic [9:0] sum;

  always_comb begin
    p    = rgb565_t'(pix);
    r8   = {p.r, p.r[4:2]};
    g8   = {p.g, p.g[5:4]};
    b8   = {p.b, p.b[4:2]};
    sum  = 10'(r8) + {1'b0, g8, 1'b0} + 10'(b8);
    gray = 8'(sum >> 2);
  end

endmodule

// File: rtl/capture_downsampler.sv
// Turns one armed RGB565 frame into a DIM x DIM grayscale image: centred crop,
// luma conversion and BLK x BLK box averaging, written word by word to the image buffer.
module capture_downsampler
  import cam_pkg::*;
#(
  parameter int SRC_W = SRC_W_DEFAULT,
  parameter int SRC_H = SRC_H_DEFAULT,
  parameter int DIM   = OUT_DIM,
  parameter int BLK   = BLOCK
)(
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic        arm,
  input  logic        pix_valid,
  input  logic [15:0] pix_data,
  input  logic        pix_sof,
  input  logic        pix_eol,
  output logic        wr_en,
  output logic [9:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy,
  output logic        frame_done
);

  localparam int LOG_BLK = $clog2(BLK);
  localparam int WIN     = DIM * BLK;
  localparam int X0      = (SRC_W - WIN) / 2;
  localparam int Y0      = (SRC_H - WIN) / 2;
  localparam int XW      = $clog2(SRC_W + 1);
  localparam int YW      = $clog2(SRC_H + 1);
  localparam int CW      = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int DW      = LOG_BLK + CW;
  localparam int ACC_W   = 2 * LOG_BLK + GRAY_W;

  localparam logic [XW-1:0]     X_LO      = XW'(X0);
  localparam logic [XW-1:0]     X_HI      = XW'(X0 + WIN);
  localparam logic [XW-1:0]     X_MAX     = XW'(SRC_W);
  localparam logic [YW-1:0]     Y_LO      = YW'(Y0);
  localparam logic [YW-1:0]     Y_HI      = YW'(Y0 + WIN);
  localparam logic [YW-1:0]     Y_MAX     = YW'(SRC_H);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DIM * DIM - 1);

  cd_state_t         state;
  cd_state_t         state_next;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;

  logic              accept;
  logic              start;
  logic              abort;
  logic              last_write;
  logic [XW-1:0]     cx;
  logic [YW-1:0]     cy;
  logic              in_win;
  logic [DW-1:0]     dx;
  logic [DW-1:0]     dy;
  logic [7:0]        gray;

  logic              s1_valid;
  logic              s1_emit;
  logic [7:0]        s1_gray;
  logic [CW-1:0]     s1_col;
  logic [CW-1:0]     s1_row;

  logic [ACC_W-1:0]  acc [DIM];

  rgb565_to_gray u_luma (
    .pix  (pix_data),
    .gray (gray)
  );

  // A sof pixel is coordinate (0,0) regardless of where the counters stood.
  always_comb begin
    accept     = pix_valid && ((state == ACTIVE) || ((state == WAIT_SOF) && pix_sof));
    start      = accept && pix_sof;
    abort      = start && (state == ACTIVE);
    last_write = wr_en && (wr_addr == LAST_ADDR);
    cx         = pix_sof ? '0 : x;
    cy         = pix_sof ? '0 : y;
    in_win     = accept && (cx >= X_LO) && (cx < X_HI) && (cy >= Y_LO) && (cy < Y_HI);
    dx         = DW'(cx - X_LO);
    dy         = DW'(cy - Y_LO);
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:     if (arm) state_next = WAIT_SOF;
      WAIT_SOF: if (pix_valid && pix_sof) state_next = ACTIVE;
      ACTIVE:   if (last_write) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Counters saturate at the frame size so overlong lines/frames never wrap into the window.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (accept) begin
      if (pix_eol) begin
        x <= '0;
        y <= (cy == Y_MAX) ? cy : cy + YW'(1);
      end else begin
        x <= (cx == X_MAX) ? cx : cx + XW'(1);
        y <= cy;
      end
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_emit  <= 1'b0;
      s1_gray  <= '0;
      s1_col   <= '0;
      s1_row   <= '0;
    end else begin
      s1_valid <= in_win;
      s1_emit  <= in_win && (&dx[LOG_BLK-1:0]) && (&dy[LOG_BLK-1:0]);
      if (in_win) begin
        s1_gray <= gray;
        s1_col  <= dx[DW-1:LOG_BLK];
        s1_row  <= dy[DW-1:LOG_BLK];
      end
    end
  end

  // A restart wipes every partial block sum; an emitting pixel closes its column's block.
  always_ff @(posedge clk_100MHz) begin
    if (reset || abort) begin
      for (int i = 0; i < DIM; i++) acc[i] <= '0;
    end else if (s1_valid) begin
      if (s1_emit) acc[s1_col] <= '0;
      else         acc[s1_col] <= acc[s1_col] + ACC_W'(s1_gray);
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
    end else begin
      wr_en      <= s1_valid && s1_emit;
      frame_done <= last_write;
      if (s1_valid && s1_emit) begin
        wr_addr <= ADDR_W'(s1_row) * ADDR_W'(DIM) + ADDR_W'(s1_col);
        wr_data <= 8'((acc[s1_col] + ACC_W'(s1_gray)) >> (2 * LOG_BLK));
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_capture_downsampler.sv
// Self-checking bench for capture_downsampler on a reduced frame geometry
// (3x3 output, 16-pixel blocks), with a block-average reference model.
module tb_capture_downsampler;
  import cam_pkg::*;

  localparam int SRC_W = 56;
  localparam int SRC_H = 52;
  localparam int DIM   = 3;
  localparam int BLK   = 16;
  localparam int X0    = (SRC_W - DIM * BLK) / 2;
  localparam int Y0    = (SRC_H - DIM * BLK) / 2;
  localparam int N_OUT = DIM * DIM;

  logic        clk_100MHz = 1'b0;
  logic        reset;
  logic        arm;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic        pix_sof;
  logic        pix_eol;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        frame_done;

  always #5 clk_100MHz = ~clk_100MHz;

  capture_downsampler #(
    .SRC_W (SRC_W),
    .SRC_H (SRC_H),
    .DIM   (DIM),
    .BLK   (BLK)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .arm        (arm),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_sof    (pix_sof),
    .pix_eol    (pix_eol),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .frame_done (frame_done)
  );

  int n_compared   = 0;
  int n_mismatched = 0;
  int cyc          = 0;
  int done_count   = 0;
  int emit_cyc0    = 0;

  logic [15:0] frame [SRC_H][SRC_W];
  int          exp_img [N_OUT];
  int          wr_addr_q [$];
  int          wr_data_q [$];
  int          wr_cyc_q  [$];
  logic        prev_wr_en   = 1'b0;
  logic [9:0]  prev_wr_addr = '0;

  typedef struct {
    logic [15:0] color;
    logic [7:0]  gray;
    string       name;
  } vec_t;

  vec_t vecs [6];

  always @(posedge clk_100MHz) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // Write log and frame_done ordering, sampled mid-cycle.
  always @(negedge clk_100MHz) begin
    if (wr_en === 1'b1) begin
      wr_addr_q.push_back(int'(wr_addr));
      wr_data_q.push_back(int'(wr_data));
      wr_cyc_q.push_back(cyc);
    end
    if (frame_done === 1'b1) begin
      done_count++;
      check_output("done_after_last_write", {31'b0, prev_wr_en && (prev_wr_addr == 10'(N_OUT - 1))}, 32'd1);
      check_output("busy_low_at_done", {31'b0, busy}, 32'd0);
    end
    prev_wr_en   = wr_en;
    prev_wr_addr = wr_addr;
  end

  function automatic int luma(input logic [15:0] p);
    int r5 = int'(p[15:11]);
    int g6 = int'(p[10:5]);
    int b5 = int'(p[4:0]);
    int r8 = r5 * 8 + r5 / 4;
    int g8 = g6 * 4 + g6 / 16;
    int b8 = b5 * 8 + b5 / 4;
    return (r8 + 2 * g8 + b8) / 4;
  endfunction

  task automatic build_model();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        int sum = 0;
        for (int by = 0; by < BLK; by++)
          for (int bx = 0; bx < BLK; bx++)
            sum += luma(frame[Y0 + r * BLK + by][X0 + c * BLK + bx]);
        exp_img[r * DIM + c] = sum / (BLK * BLK);
      end
  endtask

  task automatic fill_uniform(input logic [15:0] color);
    for (int yy = 0; yy < SRC_H; yy++)
      for (int xx = 0; xx < SRC_W; xx++) frame[yy][xx] = color;
  endtask

  task automatic fill_random();
    for (int yy = 0; yy < SRC_H; yy++)
      for (int xx = 0; xx < SRC_W; xx++) frame[yy][xx] = 16'($urandom);
  endtask

  task automatic set_block(input int r, input int c, input logic [15:0] color);
    for (int by = 0; by < BLK; by++)
      for (int bx = 0; bx < BLK; bx++) frame[Y0 + r * BLK + by][X0 + c * BLK + bx] = color;
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    done_count = 0;
  endtask

  task automatic cycle_clk();
    @(posedge clk_100MHz);
    #1;
  endtask

  // Streams lines 0..n_lines-1 of frame[], each padded with 'extra' junk pixels past SRC_W.
  task automatic apply_stimulus(input bit do_arm, input int n_lines, input int gap_pct, input int extra);
    if (do_arm) begin
      arm = 1'b1;
      cycle_clk();
      arm = 1'b0;
    end
    for (int yy = 0; yy < n_lines; yy++)
      for (int xx = 0; xx < SRC_W + extra; xx++) begin
        while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
          pix_valid = 1'b0;
          pix_data  = 16'($urandom);
          pix_sof   = 1'($urandom);
          pix_eol   = 1'($urandom);
          cycle_clk();
        end
        pix_valid = 1'b1;
        pix_sof   = (xx == 0) && (yy == 0);
        pix_eol   = (xx == SRC_W + extra - 1);
        pix_data  = (xx < SRC_W) ? frame[yy][xx] : 16'($urandom);
        if (xx == X0 + BLK - 1 && yy == Y0 + BLK - 1) emit_cyc0 = cyc;
        cycle_clk();
      end
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_eol   = 1'b0;
    repeat (4) cycle_clk();
  endtask

  task automatic check_frame(input string tag, input bit use_model);
    int n;
    if (use_model) build_model();
    n = wr_addr_q.size();
    check_output({tag, "_write_count"}, 32'(n), 32'(N_OUT));
    for (int i = 0; i < n && i < N_OUT; i++) begin
      check_output({tag, "_addr"}, 32'(wr_addr_q[i]), 32'(i));
      check_output({tag, "_data"}, 32'(wr_data_q[i]), 32'(exp_img[i]));
    end
    if (n > 0) check_output({tag, "_latency"}, 32'(wr_cyc_q[0] - emit_cyc0), 32'd2);
    check_output({tag, "_done_count"}, 32'(done_count), 32'd1);
    check_output({tag, "_busy_after"}, {31'b0, busy}, 32'd0);
    clear_log();
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_wr_en"}, {31'b0, wr_en}, 32'd0);
    check_output({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    check_output({tag, "_wr_data"}, 32'(wr_data), 32'd0);
    check_output({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check_output({tag, "_frame_done"}, {31'b0, frame_done}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{color: 16'hFFFF, gray: 8'hFF, name: "white"};
    vecs[1] = '{color: 16'hF800, gray: 8'h3F, name: "red"};
    vecs[2] = '{color: 16'h07E0, gray: 8'h7F, name: "green"};
    vecs[3] = '{color: 16'h001F, gray: 8'h3F, name: "blue"};
    vecs[4] = '{color: 16'h8410, gray: 8'h83, name: "mid_gray"};
    vecs[5] = '{color: 16'h0000, gray: 8'h00, name: "black"};

    reset     = 1'b1;
    arm       = 1'b0;
    pix_valid = 1'b0;
    pix_data  = '0;
    pix_sof   = 1'b0;
    pix_eol   = 1'b0;
    repeat (3) cycle_clk();
    reset = 1'b0;
    cycle_clk();
    check_all_zero("reset");
    clear_log();

    arm = 1'b1;
    cycle_clk();
    arm = 1'b0;
    check_output("busy_wait_sof", {31'b0, busy}, 32'd1);

    // Uniform frames: every block average equals the colour's luma.
    for (int i = 0; i < 6; i++) begin
      fill_uniform(vecs[i].color);
      for (int k = 0; k < N_OUT; k++) exp_img[k] = int'(vecs[i].gray);
      apply_stimulus(i != 0, SRC_H, (i == 2) ? 10 : 0, 0);
      check_frame(vecs[i].name, 1'b0);
    end

    apply_stimulus(1'b0, SRC_H, 0, 0);
    check_output("no_arm_writes", 32'(wr_addr_q.size()), 32'd0);
    check_output("no_arm_done", 32'(done_count), 32'd0);
    check_output("no_arm_busy", {31'b0, busy}, 32'd0);
    clear_log();

    fill_uniform(16'h0000);
    set_block(1, 2, 16'hF800);
    apply_stimulus(1'b1, SRC_H, 5, 0);
    if (wr_data_q.size() > 5) check_output("red_block_addr5", 32'(wr_data_q[5]), 32'd63);
    check_frame("red_block", 1'b1);

    fill_uniform(16'h0000);
    frame[Y0][X0]     = 16'hFFFF;
    frame[Y0][X0 - 1] = 16'hFFFF;
    apply_stimulus(1'b1, SRC_H, 5, 0);
    if (wr_data_q.size() > 0) check_output("single_pixel_addr0", 32'(wr_data_q[0]), 32'd0);
    check_frame("single_pixel", 1'b1);

    fill_uniform(16'h0000);
    set_block(0, 0, 16'hFFFF);
    apply_stimulus(1'b1, SRC_H, 5, 0);
    if (wr_data_q.size() > 0) check_output("origin_block_addr0", 32'(wr_data_q[0]), 32'hFF);
    check_frame("origin_block", 1'b1);

    // Abort mid-frame with partial sums pending, then a clean white frame.
    fill_random();
    apply_stimulus(1'b1, 30, 5, 0);
    clear_log();
    fill_uniform(16'hFFFF);
    apply_stimulus(1'b0, SRC_H, 5, 0);
    check_frame("after_abort", 1'b1);

    fill_random();
    apply_stimulus(1'b1, 20, 0, 0);
    reset = 1'b1;
    cycle_clk();
    reset = 1'b0;
    check_all_zero("mid_reset");
    clear_log();
    fill_random();
    apply_stimulus(1'b1, SRC_H, 10, 0);
    check_frame("after_reset", 1'b1);

    // Random frames, some with lines running past SRC_W.
    for (int k = 0; k < 3; k++) begin
      fill_random();
      apply_stimulus(1'b1, SRC_H, 10, (k == 1) ? 16 : k * 4);
      check_frame("random", 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
